// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ready handshake and feeds MEM/WB.
// Build option MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of forcing natural alignment.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_write,
  input  logic [DATA_WIDTH-1:0]     ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     ex_store_data,
  input  logic                      ex_mem_read,
  input  logic                      ex_mem_write,
  input  logic [1:0]                ex_mem_size,
  input  logic                      ex_mem_unsigned,
  output logic                      mem_stall,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [ADDR_WIDTH-1:0]     dmem_addr,
  output logic [DATA_WIDTH-1:0]     dmem_wdata,
  output logic [3:0]                dmem_be,
  input  logic                      dmem_ready,
  input  logic [DATA_WIDTH-1:0]     dmem_rdata,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_out,
  output logic [DATA_WIDTH-1:0]     alu_result_out,
  output logic [DATA_WIDTH-1:0]     mem_result_out,
  output logic                      write_alu_result_tag
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      misalign_trap
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]                state_q, state_d;
  logic                      req_q, req_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [3:0]                be_q, be_d;
  logic [REG_ADDR_WIDTH-1:0] regWrite_q, regWrite_d;
  logic [DATA_WIDTH-1:0]     aluResult_q, aluResult_d;
  logic [DATA_WIDTH-1:0]     memResult_q, memResult_d;
  logic                      tag_q, tag_d;
  logic [REG_ADDR_WIDTH-1:0] capRd_q, capRd_d;
  logic [DATA_WIDTH-1:0]     capAddr_q, capAddr_d;
  logic [1:0]                capOff_q, capOff_d;
  logic [1:0]                capSize_q, capSize_d;
  logic                      capUnsigned_q, capUnsigned_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                      trap_q, trap_d;
  logic                      misaligned;
`endif

  logic                  isHalf, isWord, isMemOp, issue;
  logic [1:0]            alignOff;
  logic [3:0]            beCalc;
  logic [DATA_WIDTH-1:0] wdataCalc, lane, loadData;

  // Decode the EX/MEM access: naturally aligned lane offset, byte enables, replicated store data
  always_comb begin
    isHalf  = (ex_mem_size == 2'b01);
    isWord  = ex_mem_size[1];
    isMemOp = ex_mem_read | ex_mem_write;
    if (isWord) begin
      alignOff  = 2'b00;
      beCalc    = 4'b1111;
      wdataCalc = ex_store_data;
    end else if (isHalf) begin
      alignOff  = {ex_alu_result[1], 1'b0};
      beCalc    = 4'b0011 << alignOff;
      wdataCalc = {2{ex_store_data[15:0]}};
    end else begin
      alignOff  = ex_alu_result[1:0];
      beCalc    = 4'b0001 << alignOff;
      wdataCalc = {4{ex_store_data[7:0]}};
    end
`ifdef MEM_MISALIGN_TRAP_EN
    misaligned = (isHalf && ex_alu_result[0]) || (isWord && (ex_alu_result[1:0] != 2'b00));
    issue      = isMemOp && !misaligned;
`else
    issue      = isMemOp;
`endif
  end

  // Shift the addressed lane down and extend it according to the captured size
  always_comb begin
    lane = dmem_rdata >> {capOff_q, 3'b000};
    if (capSize_q[1]) begin
      loadData = lane;
    end else if (capSize_q == 2'b01) begin
      loadData = {{(DATA_WIDTH-16){lane[15] & ~capUnsigned_q}}, lane[15:0]};
    end else begin
      loadData = {{(DATA_WIDTH-8){lane[7] & ~capUnsigned_q}}, lane[7:0]};
    end
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    regWrite_d    = '0;
    aluResult_d   = aluResult_q;
    memResult_d   = memResult_q;
    tag_d         = tag_q;
    capRd_d       = capRd_q;
    capAddr_d     = capAddr_q;
    capOff_d      = capOff_q;
    capSize_d     = capSize_q;
    capUnsigned_d = capUnsigned_q;
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (issue) begin
            state_d       = BUSY;
            req_d         = 1'b1;
            we_d          = ex_mem_write;
            addr_d        = {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
            wdata_d       = wdataCalc;
            be_d          = beCalc;
            capRd_d       = ex_reg_write;
            capAddr_d     = ex_alu_result;
            capOff_d      = alignOff;
            capSize_d     = ex_mem_size;
            capUnsigned_d = ex_mem_unsigned;
`ifdef MEM_MISALIGN_TRAP_EN
          end else if (isMemOp) begin
            trap_d      = 1'b1;
            aluResult_d = ex_alu_result;
`endif
          end else begin
            regWrite_d  = ex_reg_write;
            aluResult_d = ex_alu_result;
            tag_d       = 1'b1;
          end
        end
      end
      default: begin
        // Stores and rd=0 loads complete without a writeback
        if (dmem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!we_q) begin
            regWrite_d  = capRd_q;
            memResult_d = loadData;
            aluResult_d = capAddr_q;
            tag_d       = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_q         <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      regWrite_q    <= '0;
      aluResult_q   <= '0;
      memResult_q   <= '0;
      tag_q         <= 1'b0;
      capRd_q       <= '0;
      capAddr_q     <= '0;
      capOff_q      <= '0;
      capSize_q     <= '0;
      capUnsigned_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      regWrite_q    <= regWrite_d;
      aluResult_q   <= aluResult_d;
      memResult_q   <= memResult_d;
      tag_q         <= tag_d;
      capRd_q       <= capRd_d;
      capAddr_q     <= capAddr_d;
      capOff_q      <= capOff_d;
      capSize_q     <= capSize_d;
      capUnsigned_q <= capUnsigned_d;
`ifdef MEM_MISALIGN_TRAP_EN
      trap_q        <= trap_d;
`endif
    end
  end

  assign mem_stall            = (state_q == BUSY);
  assign dmem_req             = req_q;
  assign dmem_we              = we_q;
  assign dmem_addr            = addr_q;
  assign dmem_wdata           = wdata_q;
  assign dmem_be              = be_q;
  assign reg_write_out        = regWrite_q;
  assign alu_result_out       = aluResult_q;
  assign mem_result_out       = memResult_q;
  assign write_alu_result_tag = tag_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_trap        = trap_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver predicts requests and writebacks from a
// byte-lane model, a memory responder and a writeback monitor check them as they appear.
module tb_mem_access_stage;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitCycles;
  } reqT;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        tag;
  } wbT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_reg_write = '0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = '0;
  logic        ex_mem_unsigned = 1'b0;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [4:0]  reg_write_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_result_out;
  logic        write_alu_result_tag;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  reqT reqQ[$];
  wbT  wbQ[$];
  int  checks = 0;
  int  errors = 0;
  bit  abortResp = 1'b0;

  mem_access_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .mem_stall(mem_stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .reg_write_out(reg_write_out),
    .alu_result_out(alu_result_out), .mem_result_out(mem_result_out),
    .write_alu_result_tag(write_alu_result_tag)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Byte-lane view of an access: n bytes starting at a naturally aligned offset inside the word
  function automatic void modelAccess(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] sd, input logic [31:0] rdata,
                                      input logic uns, output logic [31:0] dAddr,
                                      output logic [3:0] be, output logic [31:0] wdata,
                                      output logic [31:0] loadVal);
    int n;
    int off;
    logic [31:0] mask;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr[1:0]);
    off = off - (off % n);
    dAddr = addr & 32'hFFFF_FFFC;
    be = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sd[8*(i % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : 32'((1 << (8*n)) - 1);
    loadVal = (rdata >> (8*off)) & mask;
    if (!uns && n < 4 && loadVal[8*n-1]) loadVal = loadVal | ~mask;
  endfunction

  task automatic applyStimulus(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] sd,
                               input logic rdEn, input logic wrEn, input logic [1:0] size,
                               input logic uns, input int waitCycles, input logic [31:0] rdata);
    reqT r;
    wbT w;
    logic [31:0] dAddr, wdata, loadVal;
    logic [3:0] be;
    int stallCnt;
    ex_valid = 1'b1; ex_reg_write = rd; ex_alu_result = alu; ex_store_data = sd;
    ex_mem_read = rdEn; ex_mem_write = wrEn; ex_mem_size = size; ex_mem_unsigned = uns;
    modelAccess(alu, size, sd, rdata, uns, dAddr, be, wdata, loadVal);
    if (rdEn || wrEn) begin
      r.we = wrEn; r.addr = dAddr; r.be = be; r.wdata = wdata;
      r.rdata = rdata; r.waitCycles = waitCycles;
      reqQ.push_back(r);
      if (rdEn && rd != 5'd0) begin
        w.rd = rd; w.alu = alu; w.mem = loadVal; w.tag = 1'b0;
        wbQ.push_back(w);
      end
    end else if (rd != 5'd0) begin
      w.rd = rd; w.alu = alu; w.mem = 32'h0; w.tag = 1'b1;
      wbQ.push_back(w);
    end
    @(posedge clk);
    @(negedge clk);
    if (rdEn || wrEn) begin
      stallCnt = 0;
      // Upstream junk while stalled must be ignored
      while (mem_stall && stallCnt < 100) begin
        ex_valid = 1'b1; ex_reg_write = 5'($urandom); ex_alu_result = $urandom;
        ex_mem_read = 1'($urandom); ex_mem_write = ~ex_mem_read; ex_mem_size = 2'($urandom);
        stallCnt++;
        @(negedge clk);
      end
      checkOutput("stall_cycles", 32'(stallCnt), 32'(waitCycles + 1));
    end else begin
      checkOutput("alu_no_stall", {31'b0, mem_stall}, 32'h0);
    end
    ex_valid = 1'b0;
  endtask

  // Memory responder: checks each request against the predicted one, answers after its wait
  initial begin
    reqT cur;
    int waitLeft;
    bit busy;
    busy = 1'b0; waitLeft = 0; dmem_ready = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      if (abortResp || rst) begin
        busy = 1'b0;
      end else begin
        if (!busy && dmem_req) begin
          if (reqQ.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL unexpected_request: got dmem_req=1 addr=0x%08h, expected no request", dmem_addr);
            cur.rdata = '0; cur.addr = dmem_addr; cur.waitCycles = 0;
          end else begin
            cur = reqQ.pop_front();
            checkOutput("req_we", {31'b0, dmem_we}, {31'b0, cur.we});
            checkOutput("req_addr", dmem_addr, cur.addr);
            checkOutput("req_be", {28'b0, dmem_be}, {28'b0, cur.be});
            if (cur.we) checkOutput("req_wdata", dmem_wdata, cur.wdata);
          end
          waitLeft = cur.waitCycles;
          busy = 1'b1;
        end else if (busy) begin
          checkOutput("req_held", {31'b0, dmem_req}, 32'h1);
          checkOutput("addr_held", dmem_addr, cur.addr);
        end
        if (busy) begin
          if (waitLeft == 0) begin
            dmem_ready = 1'b1;
            dmem_rdata = cur.rdata;
            busy = 1'b0;
          end else begin
            waitLeft--;
          end
        end
      end
    end
  end

  // Writeback monitor: every non-zero destination must match the next predicted writeback
  always @(negedge clk) begin
    wbT e;
    if (!rst && reg_write_out != 5'd0) begin
      if (wbQ.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL unexpected_writeback: got rd=%0d, expected no writeback", reg_write_out);
      end else begin
        e = wbQ.pop_front();
        checkOutput("wb_rd", {27'b0, reg_write_out}, {27'b0, e.rd});
        checkOutput("wb_alu", alu_result_out, e.alu);
        checkOutput("wb_tag", {31'b0, write_alu_result_tag}, {31'b0, e.tag});
        if (!e.tag) checkOutput("wb_mem", mem_result_out, e.mem);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reqT r;
    logic [31:0] addr;
    logic [1:0] size;
    int kind;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("rst_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("rst_addr", dmem_addr, 32'h0);
    checkOutput("rst_be", {28'b0, dmem_be}, 32'h0);
    checkOutput("rst_rd", {27'b0, reg_write_out}, 32'h0);
    checkOutput("rst_alu", alu_result_out, 32'h0);
    checkOutput("rst_tag", {31'b0, write_alu_result_tag}, 32'h0);

    applyStimulus(5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 0, 32'h0);
    applyStimulus(5'd3, 32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 3, 32'h80FF_FF00);
    applyStimulus(5'd7, 32'h202, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 0, 32'hBEEF_0000);
    applyStimulus(5'd6, 32'h41, 32'h1122_33AB, 1'b0, 1'b1, 2'd0, 1'b0, 1, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_reg_write = 5'd9; ex_alu_result = 32'h2; ex_mem_read = 1'b1;
    ex_mem_write = 1'b0; ex_mem_size = 2'd2; ex_mem_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("trap_pulse", {31'b0, misalign_trap}, 32'h1);
    checkOutput("trap_addr", alu_result_out, 32'h2);
    checkOutput("trap_rd", {27'b0, reg_write_out}, 32'h0);
    checkOutput("trap_no_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("trap_no_stall", {31'b0, mem_stall}, 32'h0);
    @(negedge clk);
    checkOutput("trap_clear", {31'b0, misalign_trap}, 32'h0);
`else
    applyStimulus(5'd9, 32'h2, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 0, 32'hCAFE_F00D);
`endif

    // Reset while an access is outstanding abandons it
    ex_valid = 1'b1; ex_reg_write = 5'd0; ex_alu_result = 32'h300; ex_mem_read = 1'b1;
    ex_mem_write = 1'b0; ex_mem_size = 2'd2;
    r.we = 1'b0; r.addr = 32'h300; r.be = 4'hF; r.wdata = '0; r.rdata = '0; r.waitCycles = 50;
    reqQ.push_back(r);
    @(posedge clk);
    @(negedge clk);
    ex_valid = 1'b0;
    checkOutput("busy_stall", {31'b0, mem_stall}, 32'h1);
    repeat (2) @(negedge clk);
    abortResp = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("abort_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("abort_be", {28'b0, dmem_be}, 32'h0);
    checkOutput("abort_addr", dmem_addr, 32'h0);
    checkOutput("abort_rd", {27'b0, reg_write_out}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    abortResp = 1'b0;

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      size = 2'($urandom);
      addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (size == 2'd1) addr[0] = 1'b0;
      else if (size != 2'd0) addr[1:0] = 2'b00;
`endif
      if (kind == 0) begin
        ex_valid = 1'b0; ex_reg_write = 5'($urandom); ex_mem_read = 1'b1;
        @(negedge clk);
      end else begin
        applyStimulus(($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), addr, $urandom,
                      kind >= 4 && kind < 7, kind >= 7, size, 1'($urandom),
                      $urandom_range(0, 3), $urandom);
      end
    end

    repeat (5) @(negedge clk);
    checkOutput("wb_queue_drained", 32'(wbQ.size()), 32'h0);
    checkOutput("req_queue_drained", 32'(reqQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the in-order pipeline. Sits between the EX/MEM register and pipeline_reg_memwb.
- Issues load/store requests to the data-memory port with a req/ready handshake.
- Aligns and sign/zero-extends load data.
- Drives the inputs of the MEM/WB register: destination register, ALU result, memory result and the select tag.
- Stalls upstream while a memory access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width (fixed 32 for byte-enable logic)
- ADDR_WIDTH, 32, data-memory byte address width
- REG_ADDR_WIDTH, 5, register index width (`REG_NUM)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_reg_write  in  REG_ADDR_WIDTH  destination register; 0 = no writeback
- ex_alu_result  in  DATA_WIDTH  ALU result; effective byte address for loads/stores
- ex_store_data  in  DATA_WIDTH  store source (rs2)
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store (mutually exclusive with ex_mem_read)
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- ex_mem_unsigned  in  1  zero-extend load (LBU/LHU)
- mem_stall  out  1  hold EX/MEM and earlier stages
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word-aligned address {addr[A-1:2],2'b00}
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory completes the request this cycle; rdata valid if read
- dmem_rdata  in  DATA_WIDTH  read data
- reg_write_out  out  REG_ADDR_WIDTH  to MEM/WB reg_write_in
- alu_result_out  out  DATA_WIDTH  to MEM/WB alu_result
- mem_result_out  out  DATA_WIDTH  to MEM/WB mem_result
- write_alu_result_tag  out  1  1 = WB takes ALU result

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs registered, reset to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, reg_write_out, alu_result_out, mem_result_out, write_alu_result_tag.
  - mem_stall=0.
  - rst asserted in BUSY aborts the access: dmem_req=0 at that edge, no writeback.
- States: IDLE, BUSY.
- mem_stall = (state==BUSY), combinational.
- An instruction is accepted only in IDLE.
- IDLE, ex_valid=0: next edge reg_write_out<=0 (bubble); other outputs hold.
- IDLE, ex_valid=1, no mem op:
  - Next edge reg_write_out<=ex_reg_write, alu_result_out<=ex_alu_result, tag<=1.
  - Stay IDLE. Latency 1 cycle.
- IDLE, ex_valid=1, load or store:
  - Next edge capture rd, address, size, unsigned into internal regs.
  - Drive dmem_req<=1, dmem_we<=ex_mem_write, address, be and wdata.
  - reg_write_out<=0; go BUSY.
- BUSY, dmem_ready=0:
  - Hold all dmem_* outputs stable.
  - reg_write_out<=0.
  - No timeout.
- BUSY, dmem_ready=1:
  - Next edge: dmem_req<=0, dmem_we<=0, state<=IDLE.
  - Load: reg_write_out<=captured rd, mem_result_out<=extracted data, alu_result_out<=address, tag<=0.
  - Store: reg_write_out<=0.
  - The next instruction is accepted in the following IDLE cycle, so minimum access cost is 2 cycles.
- Byte enables / wdata:
  - byte: be=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}
  - half: be=4'b0011<<{addr[1],1'b0}, wdata={2{sd[15:0]}}
  - word: be=4'b1111, wdata=sd
  - Loads drive the same be.
- Load extraction:
  - lane = rdata >> (8*addr[1:0]).
  - byte/half sign-extended unless unsigned; word passes through.
- Load with rd=0: access still performed; reg_write_out=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
- Defined:
  - Extra output port misalign_trap (1 bit, reset 0).
  - A misaligned access in IDLE issues no dmem_req and stays IDLE.
  - Next edge: misalign_trap<=1 for exactly one cycle, reg_write_out<=0, alu_result_out<=faulting address.
- Not defined:
  - No port.
  - Misaligned addresses are forced to natural alignment (half clears addr[0]; word clears addr[1:0]) before be/extraction, and the access proceeds normally.

Test Plan:
- ALU op rd=5, alu=0x1234, ex_valid=1 in IDLE -> next cycle reg_write_out=5, alu_result_out=0x1234, tag=1, mem_stall=0.
- LB rd=3, addr=0x103, ready after 3 wait cycles, rdata=0x80FF_FF00 -> be=1000, mem_stall=1 for 4 cycles, then reg_write_out=3, mem_result_out=0xFFFF_FF80, tag=0.
- LHU rd=7, addr=0x202, rdata=0xBEEF_0000, ready immediately -> dmem_addr=0x200, be=1100, mem_result_out=0x0000_BEEF.
- SB addr=0x41, sd=0x1122_33AB -> dmem_we=1, be=0010, wdata=0xABAB_ABAB; after ready reg_write_out=0.
- rst asserted while BUSY awaiting ready -> next edge dmem_req=0, state IDLE, all outputs 0, mem_stall=0.
- LW addr=0x2 -> with MEM_MISALIGN_TRAP_EN: no dmem_req, misalign_trap one-cycle pulse, alu_result_out=0x2. Without: dmem_addr=0x0, be=1111.
